// File: rtl/warships_pkg.sv
// Shared warships board types and geometry, used by board_mem, draw_ships and the write controller.
package warships_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    SHIP  = 2'b01,
    MISS  = 2'b10,
    HIT   = 2'b11
  } cell_t;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } wr_state_t;

  typedef logic [7:0] grid_addr_t;

  localparam int GRID_X_SIZE = 12;
  localparam int GRID_Y_SIZE = 12;
  localparam int CELL_SHIFT  = 5;

endpackage

// File: rtl/grid_hit_test.sv
// Pixel -> {inside, {y,x} cell} hit test; purely combinational, no backpressure.
module grid_hit_test
  import warships_pkg::grid_addr_t;
#(
  parameter int X_POS      = 100,
  parameter int Y_POS      = 200,
  parameter int X_SIZE     = warships_pkg::GRID_X_SIZE,
  parameter int Y_SIZE     = warships_pkg::GRID_Y_SIZE,
  parameter int CELL_SHIFT = warships_pkg::CELL_SHIFT
) (
  input  logic [11:0] i_x,
  input  logic [11:0] i_y,
  output logic        o_inside,
  output grid_addr_t  o_addr
);

  // One extra bit so the right/bottom bound never wraps for grids near the screen edge.
  localparam logic [12:0] X_LO = 13'(X_POS);
  localparam logic [12:0] X_HI = 13'(X_POS + (X_SIZE << CELL_SHIFT));
  localparam logic [12:0] Y_LO = 13'(Y_POS);
  localparam logic [12:0] Y_HI = 13'(Y_POS + (Y_SIZE << CELL_SHIFT));

  logic        w_in_x;
  logic        w_in_y;
  logic [11:0] w_rx;
  logic [11:0] w_ry;

  assign w_in_x   = ({1'b0, i_x} >= X_LO) && ({1'b0, i_x} < X_HI);
  assign w_in_y   = ({1'b0, i_y} >= Y_LO) && ({1'b0, i_y} < Y_HI);
  assign w_rx     = i_x - 12'(X_POS);
  assign w_ry     = i_y - 12'(Y_POS);
  assign o_inside = w_in_x && w_in_y;
  assign o_addr   = {4'(w_ry >> CELL_SHIFT), 4'(w_rx >> CELL_SHIFT)};

endmodule

// File: rtl/board_write_ctl.sv
// Single write-port arbiter for board_mem: clear sweep > mouse click > remote channel, one write per cycle.
// Writes and hover are registered (1-cycle latency); remote requests wait on rmt_ready while clearing or outbid.
module board_write_ctl
  import warships_pkg::grid_addr_t, warships_pkg::wr_state_t,
         warships_pkg::ST_IDLE, warships_pkg::ST_CLEAR;
#(
  parameter int         X_POS       = 100,
  parameter int         Y_POS       = 200,
  parameter int         X_SIZE      = warships_pkg::GRID_X_SIZE,
  parameter int         Y_SIZE      = warships_pkg::GRID_Y_SIZE,
  parameter int         CELL_SHIFT  = warships_pkg::CELL_SHIFT,
  parameter logic [1:0] CLEAR_VALUE = 2'b00,
  parameter bit         AUTO_CLEAR  = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clear_req,
  output logic        clear_busy,
  input  logic [11:0] mouse_x_pos,
  input  logic [11:0] mouse_y_pos,
  input  logic        mouse_left,
  input  logic        click_en,
  input  logic [1:0]  click_data,
  output logic        click_done,
  output logic        hover_valid,
  output logic [7:0]  hover_addr,
  input  logic        rmt_valid,
  output logic        rmt_ready,
  input  logic [7:0]  rmt_addr,
  input  logic [1:0]  rmt_data,
  output logic [7:0]  board_write_addr,
  output logic [1:0]  board_write_data,
  output logic        board_write_enable
);

  localparam grid_addr_t LAST_CELL = {4'(Y_SIZE - 1), 4'(X_SIZE - 1)};

  wr_state_t  r_state, w_state_nxt;
  logic       r_start_pend;
  logic       r_ml_q;
  logic       r_wr_en, w_wr_en_nxt;
  grid_addr_t r_wr_addr, w_wr_addr_nxt;
  logic [1:0] r_wr_data, w_wr_data_nxt;
  logic       r_click_done, w_click_done_nxt;
  logic       r_hover_valid;
  grid_addr_t r_hover_addr;
  logic       w_inside;
  grid_addr_t w_cell;
  logic       w_idle, w_clr_start, w_valid_click, w_rmt_xfer, w_rmt_in_range;

  grid_hit_test #(
    .X_POS(X_POS), .Y_POS(Y_POS), .X_SIZE(X_SIZE), .Y_SIZE(Y_SIZE), .CELL_SHIFT(CELL_SHIFT)
  ) u_hit (
    .i_x(mouse_x_pos), .i_y(mouse_y_pos), .o_inside(w_inside), .o_addr(w_cell)
  );

  // The post-reset auto clear behaves exactly like a clear_req on the first edge.
  assign w_idle         = (r_state == ST_IDLE);
  assign w_clr_start    = w_idle & (clear_req | r_start_pend);
  assign w_valid_click  = w_idle & mouse_left & ~r_ml_q & click_en & w_inside;
  assign rmt_ready      = w_idle & ~w_clr_start & ~w_valid_click;
  assign w_rmt_xfer     = rmt_valid & rmt_ready;
  assign w_rmt_in_range = ({1'b0, rmt_addr[3:0]} < 5'(X_SIZE)) && ({1'b0, rmt_addr[7:4]} < 5'(Y_SIZE));

  always_comb begin
    w_state_nxt      = r_state;
    w_wr_en_nxt      = 1'b0;
    w_wr_addr_nxt    = r_wr_addr;
    w_wr_data_nxt    = r_wr_data;
    w_click_done_nxt = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_clr_start) begin
          w_state_nxt   = ST_CLEAR;
          w_wr_en_nxt   = 1'b1;
          w_wr_addr_nxt = '0;
          w_wr_data_nxt = CLEAR_VALUE;
        end else if (w_valid_click) begin
          w_wr_en_nxt      = 1'b1;
          w_wr_addr_nxt    = w_cell;
          w_wr_data_nxt    = click_data;
          w_click_done_nxt = 1'b1;
        end else if (w_rmt_xfer && w_rmt_in_range) begin
          w_wr_en_nxt   = 1'b1;
          w_wr_addr_nxt = rmt_addr;
          w_wr_data_nxt = rmt_data;
        end
      end
      ST_CLEAR: begin
        // The sweep cursor is the last address written, so no separate counter is kept.
        if (r_wr_addr == LAST_CELL) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_wr_en_nxt   = 1'b1;
          w_wr_data_nxt = CLEAR_VALUE;
          if (r_wr_addr[3:0] == 4'(X_SIZE - 1)) begin
            w_wr_addr_nxt = {r_wr_addr[7:4] + 4'd1, 4'd0};
          end else begin
            w_wr_addr_nxt = {r_wr_addr[7:4], r_wr_addr[3:0] + 4'd1};
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= ST_IDLE;
      r_start_pend  <= AUTO_CLEAR;
      r_ml_q        <= 1'b0;
      r_wr_en       <= 1'b0;
      r_wr_addr     <= '0;
      r_wr_data     <= '0;
      r_click_done  <= 1'b0;
      r_hover_valid <= 1'b0;
      r_hover_addr  <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_start_pend  <= 1'b0;
      r_ml_q        <= mouse_left;
      r_wr_en       <= w_wr_en_nxt;
      r_wr_addr     <= w_wr_addr_nxt;
      r_wr_data     <= w_wr_data_nxt;
      r_click_done  <= w_click_done_nxt;
      r_hover_valid <= w_inside;
      if (w_inside) begin
        r_hover_addr <= w_cell;
      end
    end
  end

  assign clear_busy         = (r_state == ST_CLEAR);
  assign click_done         = r_click_done;
  assign hover_valid        = r_hover_valid;
  assign hover_addr         = r_hover_addr;
  assign board_write_addr   = r_wr_addr;
  assign board_write_data   = r_wr_data;
  assign board_write_enable = r_wr_en;

endmodule

// File: tb/tb_board_write_ctl.sv
// Bench for board_write_ctl: write scoreboard, hover/remote vector tables, sweep and abort sequences.
module tb_board_write_ctl;
  import warships_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clear_req = 1'b0;
  logic        clear_busy;
  logic [11:0] mouse_x_pos = '0;
  logic [11:0] mouse_y_pos = '0;
  logic        mouse_left = 1'b0;
  logic        click_en = 1'b0;
  logic [1:0]  click_data = '0;
  logic        click_done;
  logic        hover_valid;
  logic [7:0]  hover_addr;
  logic        rmt_valid = 1'b0;
  logic        rmt_ready;
  logic [7:0]  rmt_addr = '0;
  logic [1:0]  rmt_data = '0;
  logic [7:0]  board_write_addr;
  logic [1:0]  board_write_data;
  logic        board_write_enable;

  board_write_ctl dut (
    .clk(clk), .rst(rst), .clear_req(clear_req), .clear_busy(clear_busy),
    .mouse_x_pos(mouse_x_pos), .mouse_y_pos(mouse_y_pos), .mouse_left(mouse_left),
    .click_en(click_en), .click_data(click_data), .click_done(click_done),
    .hover_valid(hover_valid), .hover_addr(hover_addr),
    .rmt_valid(rmt_valid), .rmt_ready(rmt_ready), .rmt_addr(rmt_addr), .rmt_data(rmt_data),
    .board_write_addr(board_write_addr), .board_write_data(board_write_data),
    .board_write_enable(board_write_enable)
  );

  always #5 clk = ~clk;

  typedef struct { logic [7:0] addr; logic [1:0] data; } wr_t;
  typedef struct { logic [11:0] x; logic [11:0] y; logic v; logic [7:0] a; } hv_t;
  typedef struct { logic [7:0] a; logic [1:0] d; logic w; } rm_t;

  wr_t exp_q[$];
  wr_t mon_e;
  int  n_checks = 0;
  int  n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic push_sweep(input int n_cells);
    for (int k = 0; k < n_cells; k++) begin
      exp_q.push_back('{addr: {4'(k / 12), 4'(k % 12)}, data: 2'b00});
    end
  endtask

  // Every issued write must match the head of the expected queue.
  always @(negedge clk) begin
    if (board_write_enable === 1'b1) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_errors++;
        $display("FAIL unexpected_write: got addr 0x%0h data %0d, required no write at %0t",
                 board_write_addr, board_write_data, $time);
      end else begin
        mon_e = exp_q.pop_front();
        if (board_write_addr !== mon_e.addr || board_write_data !== mon_e.data) begin
          n_errors++;
          $display("FAIL write: got addr 0x%0h data %0d, required addr 0x%0h data %0d at %0t",
                   board_write_addr, board_write_data, mon_e.addr, mon_e.data, $time);
        end
      end
    end
  end

  task automatic sweep_check(input string name, input bit poke);
    int n_busy = 0, n_en = 0, n_mis = 0, n_done = 0, n_rdy = 0;
    for (int i = 0; i < 150; i++) begin
      step();
      n_busy += int'(clear_busy);
      n_en   += int'(board_write_enable);
      n_done += int'(click_done);
      if (clear_busy !== board_write_enable) n_mis++;
      if (clear_busy && rmt_ready) n_rdy++;
      clear_req = 1'b0;
      if (poke && i == 10) begin
        mouse_x_pos = 12'd100; mouse_y_pos = 12'd200; click_en = 1'b1; click_data = SHIP; mouse_left = 1'b1;
      end
      if (poke && i == 20) clear_req = 1'b1;
    end
    chk({name, "_busy_cycles"}, n_busy, 144);
    chk({name, "_en_cycles"}, n_en, 144);
    chk({name, "_busy_en_mismatch"}, n_mis, 0);
    chk({name, "_click_during_clear"}, n_done, 0);
    chk({name, "_rdy_during_clear"}, n_rdy, 0);
    chk({name, "_end_en"}, board_write_enable, 0);
    chk({name, "_q_empty"}, exp_q.size(), 0);
    #1 chk({name, "_idle_rdy"}, rmt_ready, 1);
    mouse_left = 1'b0;
    click_en = 1'b0;
  endtask

  task automatic do_click(input string name, input logic [11:0] x, input logic [11:0] y,
                          input logic en, input logic [1:0] d, input logic exp_wr, input logic [7:0] a);
    mouse_x_pos = x; mouse_y_pos = y; mouse_left = 1'b0; click_en = en; click_data = d;
    step();
    mouse_left = 1'b1;
    if (exp_wr) exp_q.push_back('{addr: a, data: d});
    step();
    chk({name, "_done"}, click_done, exp_wr);
    chk({name, "_en"}, board_write_enable, exp_wr);
    step();
    chk({name, "_done_pulse"}, click_done, 0);
    mouse_left = 1'b0; click_en = 1'b0;
    step();
  endtask

  hv_t hv_tab[11];
  rm_t rm_tab[5];

  initial begin
    int n_done;
    hv_tab[0]  = '{12'd100,  12'd200,  1'b1, 8'h00};
    hv_tab[1]  = '{12'd483,  12'd551,  1'b1, 8'hAB};
    hv_tab[2]  = '{12'd484,  12'd200,  1'b0, 8'hAB};
    hv_tab[3]  = '{12'd99,   12'd200,  1'b0, 8'hAB};
    hv_tab[4]  = '{12'd131,  12'd231,  1'b1, 8'h00};
    hv_tab[5]  = '{12'd132,  12'd232,  1'b1, 8'h11};
    hv_tab[6]  = '{12'd100,  12'd583,  1'b1, 8'hB0};
    hv_tab[7]  = '{12'd100,  12'd584,  1'b0, 8'hB0};
    hv_tab[8]  = '{12'd0,    12'd0,    1'b0, 8'hB0};
    hv_tab[9]  = '{12'd4095, 12'd4095, 1'b0, 8'hB0};
    hv_tab[10] = '{12'd300,  12'd400,  1'b1, 8'h66};
    rm_tab[0]  = '{8'h0C, 2'b01, 1'b0};
    rm_tab[1]  = '{8'hC0, 2'b10, 1'b0};
    rm_tab[2]  = '{8'hBB, 2'b11, 1'b1};
    rm_tab[3]  = '{8'h00, 2'b01, 1'b1};
    rm_tab[4]  = '{8'hFF, 2'b01, 1'b0};

    #2 rst = 1'b0;
    step(3);
    chk("rst_busy", clear_busy, 0);
    chk("rst_en", board_write_enable, 0);
    chk("rst_addr", board_write_addr, 0);
    chk("rst_data", board_write_data, 0);
    chk("rst_click_done", click_done, 0);
    chk("rst_hover_valid", hover_valid, 0);
    chk("rst_hover_addr", hover_addr, 0);
    chk("rst_rmt_ready", rmt_ready, 0);

    push_sweep(144);
    rst = 1'b1;
    sweep_check("auto_clear", 1'b0);

    for (int i = 0; i < 11; i++) begin
      mouse_x_pos = hv_tab[i].x; mouse_y_pos = hv_tab[i].y;
      step();
      chk($sformatf("hover%0d_valid", i), hover_valid, hv_tab[i].v);
      chk($sformatf("hover%0d_addr", i), hover_addr, hv_tab[i].a);
    end

    mouse_x_pos = 12'd100; mouse_y_pos = 12'd200; click_en = 1'b1; click_data = SHIP;
    step();
    mouse_left = 1'b1;
    exp_q.push_back('{addr: 8'h00, data: SHIP});
    n_done = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      n_done += int'(click_done);
    end
    chk("held_click_done_count", n_done, 1);
    mouse_left = 1'b0;
    step();

    do_click("click_ab", 12'd483, 12'd551, 1'b1, HIT, 1'b1, 8'hAB);
    do_click("click_x484", 12'd484, 12'd200, 1'b1, SHIP, 1'b0, 8'h00);
    do_click("click_x99", 12'd99, 12'd200, 1'b1, SHIP, 1'b0, 8'h00);
    do_click("click_dis", 12'd300, 12'd400, 1'b0, MISS, 1'b0, 8'h00);
    do_click("click_b0", 12'd100, 12'd583, 1'b1, MISS, 1'b1, 8'hB0);

    mouse_x_pos = 12'd164; mouse_y_pos = 12'd264; click_en = 1'b1; click_data = MISS;
    step();
    mouse_left = 1'b1; rmt_valid = 1'b1; rmt_addr = 8'h35; rmt_data = HIT;
    exp_q.push_back('{addr: 8'h22, data: MISS});
    #1 chk("click_vs_rmt_ready", rmt_ready, 0);
    step();
    chk("click_vs_rmt_done", click_done, 1);
    #1 chk("rmt_after_click_ready", rmt_ready, 1);
    exp_q.push_back('{addr: 8'h35, data: HIT});
    step();
    rmt_valid = 1'b0;
    chk("rmt_after_click_en", board_write_enable, 1);
    mouse_left = 1'b0; click_en = 1'b0;
    step();

    for (int i = 0; i < 5; i++) begin
      rmt_valid = 1'b1; rmt_addr = rm_tab[i].a; rmt_data = rm_tab[i].d;
      if (rm_tab[i].w) exp_q.push_back('{addr: rm_tab[i].a, data: rm_tab[i].d});
      #1 chk($sformatf("rmt%0d_ready", i), rmt_ready, 1);
      step();
      rmt_valid = 1'b0;
      chk($sformatf("rmt%0d_en", i), board_write_enable, rm_tab[i].w);
      step();
    end
    chk("pre_clear_q_empty", exp_q.size(), 0);

    rmt_valid = 1'b1; rmt_addr = 8'h44; rmt_data = SHIP; clear_req = 1'b1;
    push_sweep(51);
    #1 chk("clear_vs_rmt_ready", rmt_ready, 0);
    step();
    clear_req = 1'b0;
    chk("clear_started_busy", clear_busy, 1);
    #1 chk("clear_rmt_pending", rmt_ready, 0);
    step(50);
    #1 chk("abort_at_cell50", board_write_addr, 8'h42);
    rst = 1'b0;
    rmt_valid = 1'b0;
    #1;
    chk("abort_en", board_write_enable, 0);
    chk("abort_busy", clear_busy, 0);
    chk("abort_addr", board_write_addr, 0);
    chk("abort_data", board_write_data, 0);
    chk("abort_q_empty", exp_q.size(), 0);
    step(2);
    push_sweep(144);
    rst = 1'b1;
    sweep_check("restart_clear", 1'b1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
